hbm_axi_rd_dma: RTL and testbench
=================================

HBM_AXI_RD_DMA -- requirements
Module: hbm_axi_rd_dma

Interface
REQ-001 SHALL have parameter M_AXI_ID_WIDTH, default 2, AXI ID width.
REQ-002 SHALL have parameter M_AXI_DATA_WIDTH, default 128, data bus width in bits (32..1024, power of 2).
REQ-003 SHALL have parameter M_AXI_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per AR burst (1..256).
REQ-005 SHALL have parameter RD_ID, default 0, constant ARID value.
REQ-006 SHALL use one clock and an asynchronous, active-low reset. Ports:
  M_AXI_ACLK  in  1  clock
  M_AXI_ARESETN  in  1  async active-low reset
  cmd_valid/cmd_ready  in/out  1  command handshake
  cmd_addr  in  M_AXI_ADDR_WIDTH  start byte address
  cmd_beats  in  20  total beats to read
  dout_valid/dout_ready  out/in  1  output stream handshake
  dout_data  out  M_AXI_DATA_WIDTH  read data
  dout_last  out  1  final beat of the command
  busy  out  1  command in progress
  done  out  1  one-cycle completion pulse
  err  out  1  sticky protocol/response error
  M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARVALID  out  AXI AR channel
  M_AXI_ARREADY  in  1
  M_AXI_RID/RDATA/RRESP/RLAST/RVALID  in  AXI R channel
  M_AXI_RREADY  out  1

Function
REQ-007 SHALL implement FSM IDLE -> ADDR -> DATA -> (ADDR | DONE) -> IDLE.
REQ-008 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch addr (low log2(bytes) bits forced 0) and beats; go DONE if beats==0, else ADDR.
REQ-009 ADDR: ARVALID=1, ARADDR/ARLEN stable until ARREADY; on ARVALID&ARREADY go DATA next cycle.
REQ-010 Burst beats SHALL equal min(remaining, MAX_BURST_LEN, (4096-addr[11:0])/(DATA_WIDTH/8)); ARLEN = beats-1; a burst never crosses a 4 KB boundary.
REQ-011 ARSIZE=log2(DATA_WIDTH/8), ARBURST=INCR (2'b01), ARID=RD_ID, ARLOCK/ARCACHE/ARPROT/ARQOS=0.
REQ-012 DATA: M_AXI_RREADY=dout_ready, dout_valid=M_AXI_RVALID, dout_data=M_AXI_RDATA (zero-latency pass-through, no buffering); both 0 outside DATA.
REQ-013 Each R handshake SHALL decrement remaining by 1; on the burst's final beat go ADDR with addr += beats*bytes if remaining>0, else DONE.
REQ-014 dout_last SHALL be 1 only on the final beat of the whole command.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in ADDR, DATA, DONE.
REQ-016 Only one AR burst outstanding at any time; cmd_valid while busy is not accepted.
REQ-017 End-of-burst SHALL be determined by the internal beat counter, not RLAST.

Reset
REQ-018 While M_AXI_ARESETN=0: state IDLE, ARVALID=0, ARADDR=0, ARLEN=0, RREADY=0, dout_valid=0, done=0, busy=0, err=0, cmd_ready=0.
REQ-019 Reset asserted mid-command SHALL abandon it; after release cmd_ready=1 next cycle.

Configuration
REQ-020 With HBM_RD_RESP_CHECK_EN defined, err SHALL set on any R handshake with RRESP!=0, RID!=RD_ID, or RLAST!=(internal last-of-burst), and clear on the next command acceptance.
REQ-021 Without HBM_RD_RESP_CHECK_EN, err SHALL be tied 0 and no check logic is generated.

Structure
REQ-022 Package hbm_rd_dma_pkg SHALL hold the FSM state enum, AXI_BURST_INCR, AXI_RESP_OKAY and BOUNDARY_4K constants.
REQ-023 Burst length computation SHALL be a combinational sub-module hbm_rd_burst_calc (inputs addr, remaining; output beats).

Verification (128-bit data, MAX_BURST_LEN=16, AXI slave memory model)
REQ-024 addr 0x0, beats 4 -> one AR ARLEN=3; 4 dout beats; dout_last on 4th; done pulse one cycle after the last beat.
REQ-025 addr 0xFC0, beats 8 -> AR 0xFC0 ARLEN=3 then AR 0x1000 ARLEN=3; data matches memory.
REQ-026 addr 0x0, beats 40 -> ARs 0x000/len 15, 0x100/len 15, 0x200/len 7; 40 beats in order.
REQ-027 beats 0 -> no ARVALID; done one cycle after acceptance.
REQ-028 dout_ready random 50% -> RREADY mirrors it; no lost/duplicated beats.
REQ-029 Reset pulsed during DATA -> all outputs at reset values; next command completes normally; with HBM_RD_RESP_CHECK_EN, injected RRESP=2 -> err=1 until next accept.

Source files
------------

// File: rtl/hbm_rd_dma_pkg.sv
// Shared definitions for the HBM AXI read DMA: FSM state encoding and the
// AXI constants the burst engine relies on.
`timescale 1ns/1ps
package hbm_rd_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } hbm_rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;
    localparam int         CMD_BEATS_W    = 20;

endpackage

// File: rtl/hbm_rd_burst_calc.sv
// Combinational burst sizing: the next AR burst is the smallest of the beats
// still owed, the configured maximum, and the beats left before the 4 KB page
// boundary, so a burst never crosses a page.
`timescale 1ns/1ps
module hbm_rd_burst_calc
    import hbm_rd_dma_pkg::*;
#(
    parameter int M_AXI_DATA_WIDTH = 128,
    parameter int MAX_BURST_LEN    = 16
) (
    input  logic [11:0]            addr,
    input  logic [CMD_BEATS_W-1:0] remaining,
    output logic [8:0]             beats
);

    localparam int                     BYTES_LG = $clog2(M_AXI_DATA_WIDTH / 8);
    localparam logic [CMD_BEATS_W-1:0] MAX_LEN  = CMD_BEATS_W'(MAX_BURST_LEN);

    logic [12:0]            to_boundary;
    logic [CMD_BEATS_W-1:0] page_beats;
    logic [CMD_BEATS_W-1:0] pick;

    // Minimum of remaining beats, maximum burst and beats left in the page
    always_comb begin
        to_boundary = 13'(BOUNDARY_4K) - {1'b0, addr};
        page_beats  = CMD_BEATS_W'(to_boundary >> BYTES_LG);
        pick        = remaining;
        if (pick > MAX_LEN) begin
            pick = MAX_LEN;
        end
        if (pick > page_beats) begin
            pick = page_beats;
        end
        beats = 9'(pick);
    end

endmodule

// File: rtl/hbm_axi_rd_dma.sv
// HBM AXI read DMA: turns a (start address, beat count) command into a
// sequence of page-safe INCR bursts with one burst outstanding, and passes
// the read data straight through to a valid/ready stream.
// Optional build macro HBM_RD_RESP_CHECK_EN adds a sticky err flag for bad
// RRESP, wrong RID or RLAST disagreeing with the internal beat counter.
//
// Handshake rule for cmd, dout and AXI channels: a transfer happens on a
// rising clock edge where valid and ready are both 1; valid never waits on
// ready, and data is taken only on that edge.
`timescale 1ns/1ps
module hbm_axi_rd_dma
    import hbm_rd_dma_pkg::*;
#(
    parameter int M_AXI_ID_WIDTH   = 2,
    parameter int M_AXI_DATA_WIDTH = 128,
    parameter int M_AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN    = 16,
    parameter int RD_ID            = 0
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [CMD_BEATS_W-1:0]        cmd_beats,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [M_AXI_DATA_WIDTH-1:0]   dout_data,
    output logic                          dout_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    state_dbg,
    output logic [M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARQOS,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int BYTES_LG = $clog2(M_AXI_DATA_WIDTH / 8);
    localparam logic [M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~(M_AXI_ADDR_WIDTH'(M_AXI_DATA_WIDTH / 8 - 1));
    localparam logic [M_AXI_ID_WIDTH-1:0] RD_ID_V = M_AXI_ID_WIDTH'(RD_ID);

    hbm_rd_state_e              state;
    hbm_rd_state_e              state_nxt;
    logic [M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [CMD_BEATS_W-1:0]     remaining_q;
    logic [8:0]                 burst_q;
    logic [8:0]                 beat_left_q;
    logic [8:0]                 calc_beats;
    logic                       cmd_fire;
    logic                       ar_fire;
    logic                       r_fire;
    logic                       burst_end;

    hbm_rd_burst_calc #(
        .M_AXI_DATA_WIDTH (M_AXI_DATA_WIDTH),
        .MAX_BURST_LEN    (MAX_BURST_LEN)
    ) u_burst_calc (
        .addr      (addr_q[11:0]),
        .remaining (remaining_q),
        .beats     (calc_beats)
    );

    // Command side: only accepted when idle and out of reset
    assign cmd_ready = (state == ST_IDLE) && M_AXI_ARESETN;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // AR channel: addr_q/remaining_q are frozen in ADDR, so ARADDR/ARLEN hold
    assign M_AXI_ARVALID = (state == ST_ADDR);
    assign ar_fire       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = (state == ST_ADDR) ? 8'(calc_beats - 9'd1) : 8'd0;
    assign M_AXI_ARSIZE  = 3'(BYTES_LG);
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARID    = RD_ID_V;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARQOS   = 4'd0;

    // R channel is a zero-latency pass-through while in DATA
    assign M_AXI_RREADY = (state == ST_DATA) && dout_ready;
    assign dout_valid   = (state == ST_DATA) && M_AXI_RVALID;
    assign dout_data    = (state == ST_DATA) ? M_AXI_RDATA : '0;
    assign r_fire       = dout_valid && dout_ready;
    assign burst_end    = (beat_left_q == 9'd1);
    assign dout_last    = dout_valid && (remaining_q == CMD_BEATS_W'(1));

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    // Next-state decode; end of burst comes from the beat counter, not RLAST
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = (cmd_beats == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_fire) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_fire && burst_end) begin
                    state_nxt = (remaining_q == CMD_BEATS_W'(1)) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, address walk and beat accounting
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            beat_left_q <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                addr_q      <= cmd_addr & ALIGN_MASK;
                remaining_q <= cmd_beats;
            end
            if (ar_fire) begin
                burst_q     <= calc_beats;
                beat_left_q <= calc_beats;
            end
            if (r_fire) begin
                remaining_q <= remaining_q - CMD_BEATS_W'(1);
                beat_left_q <= beat_left_q - 9'd1;
                if (burst_end) begin
                    addr_q <= addr_q + (M_AXI_ADDR_WIDTH'(burst_q) << BYTES_LG);
                end
            end
        end
    end

`ifdef HBM_RD_RESP_CHECK_EN
    logic err_q;
    logic resp_bad;

    assign resp_bad = (M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RID != RD_ID_V) ||
                      (M_AXI_RLAST != burst_end);

    // Sticky error, cleared when the next command is accepted
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            err_q <= 1'b0;
        end else if (cmd_fire) begin
            err_q <= 1'b0;
        end else if (r_fire && resp_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_r_status;

    assign err             = 1'b0;
    assign unused_r_status = ^{M_AXI_RID, M_AXI_RRESP, M_AXI_RLAST};
`endif

endmodule

// File: tb/tb_hbm_axi_rd_dma.sv
// Bench for hbm_axi_rd_dma: AXI slave memory model with random ARREADY and
// RVALID gaps, reference model computing expected AR bursts and data beats
// from page/burst arithmetic, directed and randomized commands.
`timescale 1ns/1ps
module tb_hbm_axi_rd_dma;

    localparam int IDW = 2;
    localparam int DW  = 128;
    localparam int AW  = 32;

`ifdef HBM_RD_RESP_CHECK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_addr;
    logic [19:0]    cmd_beats;
    logic           dout_valid;
    logic           dout_ready = 1'b1;
    logic [DW-1:0]  dout_data;
    logic           dout_last;
    logic           busy;
    logic           done;
    logic           err;
    logic [1:0]     state_dbg;
    logic [IDW-1:0] m_arid;
    logic [AW-1:0]  m_araddr;
    logic [7:0]     m_arlen;
    logic [2:0]     m_arsize;
    logic [1:0]     m_arburst;
    logic           m_arlock;
    logic [3:0]     m_arcache;
    logic [2:0]     m_arprot;
    logic [3:0]     m_arqos;
    logic           m_arvalid;
    logic           m_arready;
    logic [IDW-1:0] m_rid;
    logic [DW-1:0]  m_rdata;
    logic [1:0]     m_rresp;
    logic           m_rlast;
    logic           m_rvalid;
    logic           m_rready;

    hbm_axi_rd_dma #(
        .M_AXI_ID_WIDTH   (IDW),
        .M_AXI_DATA_WIDTH (DW),
        .M_AXI_ADDR_WIDTH (AW),
        .MAX_BURST_LEN    (16),
        .RD_ID            (0)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_data     (dout_data),
        .dout_last     (dout_last),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .state_dbg     (state_dbg),
        .M_AXI_ARID    (m_arid),
        .M_AXI_ARADDR  (m_araddr),
        .M_AXI_ARLEN   (m_arlen),
        .M_AXI_ARSIZE  (m_arsize),
        .M_AXI_ARBURST (m_arburst),
        .M_AXI_ARLOCK  (m_arlock),
        .M_AXI_ARCACHE (m_arcache),
        .M_AXI_ARPROT  (m_arprot),
        .M_AXI_ARQOS   (m_arqos),
        .M_AXI_ARVALID (m_arvalid),
        .M_AXI_ARREADY (m_arready),
        .M_AXI_RID     (m_rid),
        .M_AXI_RDATA   (m_rdata),
        .M_AXI_RRESP   (m_rresp),
        .M_AXI_RLAST   (m_rlast),
        .M_AXI_RVALID  (m_rvalid),
        .M_AXI_RREADY  (m_rready)
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            last_hs_cyc = -1;
    int            hs_cnt = 0;
    bit            rand_ready = 1'b0;
    logic [AW-1:0] inject_addr = '1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: bursts split at 16 beats and at every 4 KB page
    task automatic push_model(input logic [AW-1:0] addr, input int beats);
        logic [AW-1:0] a;
        int rem;
        int n;
        int room;
        a = addr & 32'hFFFF_FFF0;
        for (int i = 0; i < beats; i++) begin
            exp_q.push_back(mem_word(a + 32'(16 * i)));
            exp_last_q.push_back(i == beats - 1);
        end
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 16;
            n = rem;
            if (n > 16) n = 16;
            if (n > room) n = room;
            ar_addr_q.push_back(a);
            ar_len_q.push_back(8'(n - 1));
            a = a + 32'(n * 16);
            rem -= n;
        end
    endtask

    // ---------------- AXI slave memory model ----------------
    logic [AW-1:0] r_addr;
    int            r_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arready <= 1'b0;
            m_rvalid  <= 1'b0;
            m_rdata   <= '0;
            m_rlast   <= 1'b0;
            m_rresp   <= 2'b00;
            m_rid     <= '0;
            r_addr    <= '0;
            r_left    <= 0;
        end else begin
            m_arready <= ($urandom_range(0, 3) != 0);
            if (m_arvalid && m_arready) begin
                r_addr <= m_araddr;
                r_left <= int'(m_arlen) + 1;
            end else if ((!m_rvalid || m_rready) && r_left > 0 && $urandom_range(0, 3) != 0) begin
                m_rvalid <= 1'b1;
                m_rdata  <= mem_word(r_addr);
                m_rlast  <= (r_left == 1);
                m_rresp  <= (r_addr == inject_addr) ? 2'b10 : 2'b00;
                r_addr   <= r_addr + 32'd16;
                r_left   <= r_left - 1;
            end else if (m_rready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- output-stream ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (m_arvalid && m_arready) begin
                if (ar_addr_q.size() == 0) begin
                    check("ar_unexpected", m_arvalid, 1'b0);
                end else begin
                    check("araddr", m_araddr, ar_addr_q.pop_front());
                    check("arlen", m_arlen, ar_len_q.pop_front());
                end
                check("ar_fixed", {m_arid, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos},
                      {2'd0, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
            end
            if (dout_valid) begin
                check("rready_mirror", m_rready, dout_ready);
            end
            if ((m_rvalid && m_rready) || (dout_valid && dout_ready)) begin
                check("beat_passthru", m_rvalid && m_rready, dout_valid && dout_ready);
            end
            if (dout_last && !dout_valid) begin
                check("last_without_valid", dout_last, 1'b0);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", dout_valid, 1'b0);
                end else begin
                    check("dout_data", dout_data, exp_q.pop_front());
                    check("dout_last", dout_last, exp_last_q.pop_front());
                end
                last_hs_cyc = cyc;
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string pfx);
        check({pfx, "_cmd_ready"}, cmd_ready, 1'b0);
        check({pfx, "_arvalid"}, m_arvalid, 1'b0);
        check({pfx, "_araddr"}, m_araddr, 32'd0);
        check({pfx, "_arlen"}, m_arlen, 8'd0);
        check({pfx, "_rready"}, m_rready, 1'b0);
        check({pfx, "_dout_valid"}, dout_valid, 1'b0);
        check({pfx, "_done"}, done, 1'b0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_err"}, err, 1'b0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] addr, input int beats, input bit exp_err);
        int start_done;
        int acc_cyc;
        int waited;
        push_model(addr, beats);
        cmd_addr  = addr;
        cmd_beats = 20'(beats);
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            step();
            waited++;
        end
        acc_cyc    = cyc;
        start_done = done_cnt;
        step();
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("err_cleared_on_accept", err, 1'b0);
        waited = 0;
        while (done_cnt == start_done && waited < 3000) begin
            step();
            waited++;
        end
        check("done_seen", done_cnt - start_done, 1);
        if (beats == 0) begin
            check("done_timing_zero", done_cyc, acc_cyc + 1);
        end else begin
            check("done_timing", done_cyc, last_hs_cyc + 1);
        end
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("beats_drained", exp_q.size(), 0);
        check("ars_drained", ar_addr_q.size(), 0);
        check("err_after_cmd", err, exp_err);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        int waited;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        rst_n     = 1'b0;
        repeat (3) step();
        check_reset("rst");
        rst_n = 1'b1;
        step();
        check("cmd_ready_after_rst", cmd_ready, 1'b1);

        run_cmd(32'h0000_0000, 4, 1'b0);
        run_cmd(32'h0000_0FC0, 8, 1'b0);
        run_cmd(32'h0000_0000, 40, 1'b0);
        run_cmd(32'h0000_1234, 0, 1'b0);
        run_cmd(32'h0000_2FF7, 3, 1'b0);

        rand_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cmd(32'($urandom_range(0, 32'h7FFF)), $urandom_range(1, 50), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            run_cmd(32'h5000 - 32'(16 * $urandom_range(1, 20)), $urandom_range(5, 40), 1'b0);
        end
        rand_ready = 1'b0;

        // Reset in the middle of a data burst
        push_model(32'h0000_0400, 48);
        cmd_addr  = 32'h0000_0400;
        cmd_beats = 20'd48;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        base   = hs_cnt;
        waited = 0;
        while (hs_cnt < base + 5 && waited < 500) begin
            step();
            waited++;
        end
        check("beats_before_reset", hs_cnt - base >= 5, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        exp_q.delete();
        exp_last_q.delete();
        ar_addr_q.delete();
        ar_len_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("cmd_ready_after_mid_rst", cmd_ready, 1'b1);
        run_cmd(32'h0000_1000, 20, 1'b0);

        // Error response on one beat, sticky until the next accept
        inject_addr = 32'h0000_2030;
        run_cmd(32'h0000_2000, 10, RESP_CHK);
        inject_addr = '1;
        repeat (3) step();
        check("err_sticky_idle", err, RESP_CHK);
        run_cmd(32'h0000_3000, 5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
